// File: rtl/counter_pkg.sv
// Shared constants for the counting primitives: selects wrap or saturate
// behaviour at the count boundaries.
package counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

endpackage : counter_pkg

// File: rtl/counter_nbit_updown.sv
// Parametrised up/down counter with modulus, clear/load, wrap or saturate
// mode, a combinational terminal-count flag and a registered boundary pulse.
module counter_nbit_updown
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 3,
  parameter longint MOD      = 64'sd1 << WIDTH,
  parameter int     SATURATE = CNT_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  // Boundaries are held one bit wider so MOD = 2**WIDTH is representable.
  localparam logic [WIDTH:0] MOD_W    = MOD[WIDTH:0];
  localparam logic [WIDTH:0] MAX_W    = MOD_W - {{WIDTH{1'b0}}, 1'b1};
  localparam bit             SAT_MODE = (SATURATE == CNT_SAT);

  if ((WIDTH < 1) || (WIDTH > 32) || (MOD < 64'sd2) || (MOD > (64'sd1 << WIDTH))) begin : g_bad_params
    $error("counter_nbit_updown: illegal WIDTH/MOD combination");
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;
  logic [WIDTH:0]   cnt_ext_s;
  logic [WIDTH:0]   lv_ext_s;
  logic             at_max_s;
  logic             at_zero_s;
  logic             boundary_s;
  logic             lv_ok_s;

  assign cnt_ext_s  = {1'b0, count_q};
  assign lv_ext_s   = {1'b0, load_value};
  assign at_max_s   = (cnt_ext_s == MAX_W);
  assign at_zero_s  = (count_q == {WIDTH{1'b0}});
  assign lv_ok_s    = (lv_ext_s < MOD_W);

  // One boundary comparator feeds both tc and the wrap pulse.
  assign boundary_s = up_down ? at_max_s : at_zero_s;
  assign tc         = en & boundary_s;

  // Next-state selection: clear, then load, then enabled step, else hold.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = {WIDTH{1'b0}};
    end else if (load) begin
      count_d = lv_ok_s ? load_value : MAX_W[WIDTH-1:0];
    end else if (en) begin
      wrap_d = boundary_s;
      if (boundary_s) begin
        if (SAT_MODE) begin
          count_d = count_q;
        end else begin
          count_d = up_down ? {WIDTH{1'b0}} : MAX_W[WIDTH-1:0];
        end
      end else begin
        count_d = up_down ? (count_q + WIDTH'(1'b1)) : (count_q - WIDTH'(1'b1));
      end
    end else begin
      count_d = count_q;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= {WIDTH{1'b0}};
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule : counter_nbit_updown

// File: tb/tb_counter_nbit_updown.sv
// Scoreboard bench: three counter variants share one stimulus stream and are
// checked against a behavioural model plus directed expected sequences.
module tb_counter_nbit_updown;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       up_down;
  logic       clear;
  logic       load;
  logic [2:0] load_value;
  logic [2:0] cnt_a, cnt_b, cnt_c;
  logic       tc_a, tc_b, tc_c;
  logic       wrap_a, wrap_b, wrap_c;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int cnt;
    int wrp;
  } exp_t;

  exp_t q[$];
  int   m_cnt[3];
  int   mods[3] = '{6, 6, 8};
  int   sats[3] = '{CNT_WRAP, CNT_SAT, CNT_WRAP};

  counter_nbit_updown #(.WIDTH(3), .MOD(6), .SATURATE(CNT_WRAP)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .clear(clear),
    .load(load), .load_value(load_value), .count(cnt_a), .tc(tc_a), .wrap(wrap_a));

  counter_nbit_updown #(.WIDTH(3), .MOD(6), .SATURATE(CNT_SAT)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .clear(clear),
    .load(load), .load_value(load_value), .count(cnt_b), .tc(tc_b), .wrap(wrap_b));

  counter_nbit_updown dut_c (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .clear(clear),
    .load(load), .load_value(load_value), .count(cnt_c), .tc(tc_c), .wrap(wrap_c));

  always #5 clk = ~clk;

  function automatic int obs_cnt(int i);
    case (i)
      0:       return int'(cnt_a);
      1:       return int'(cnt_b);
      default: return int'(cnt_c);
    endcase
  endfunction

  function automatic int obs_tc(int i);
    case (i)
      0:       return int'(tc_a);
      1:       return int'(tc_b);
      default: return int'(tc_c);
    endcase
  endfunction

  function automatic int obs_wrap(int i);
    case (i)
      0:       return int'(wrap_a);
      1:       return int'(wrap_b);
      default: return int'(wrap_c);
    endcase
  endfunction

  function automatic int model_tc(int i, bit e, bit ud);
    int c = m_cnt[i];
    return (e && ((ud && c == mods[i] - 1) || (!ud && c == 0))) ? 1 : 0;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0d exp=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, check tc before the edge, predict and check after it.
  task automatic step(bit e, bit ud, bit clr, bit ld, int lv);
    exp_t x;
    en = e; up_down = ud; clear = clr; load = ld; load_value = 3'(lv);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      int t = model_tc(i, e, ud);
      chk($sformatf("tc%0d", i), obs_tc(i), t);
      x.wrp = 0;
      if (clr) x.cnt = 0;
      else if (ld) x.cnt = (lv < mods[i]) ? lv : mods[i] - 1;
      else if (e) begin
        x.wrp = t;
        if (ud) x.cnt = (m_cnt[i] == mods[i] - 1) ? ((sats[i] == CNT_SAT) ? m_cnt[i] : 0) : m_cnt[i] + 1;
        else    x.cnt = (m_cnt[i] == 0) ? ((sats[i] == CNT_SAT) ? 0 : mods[i] - 1) : m_cnt[i] - 1;
      end else x.cnt = m_cnt[i];
      m_cnt[i] = x.cnt;
      q.push_back(x);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      x = q.pop_front();
      chk($sformatf("cnt%0d", i), obs_cnt(i), x.cnt);
      chk($sformatf("wrap%0d", i), obs_wrap(i), x.wrp);
    end
  endtask

  int seq_a[10]  = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4};
  int wrp_a[10]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
  int seq_b[10]  = '{1, 2, 3, 4, 5, 5, 5, 5, 5, 5};
  int wrp_b[10]  = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
  int seq_c[10]  = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
  int wrp_c[10]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  int dseq_a[4]  = '{5, 4, 3, 2};
  int dwrp_a[4]  = '{1, 0, 0, 0};

  initial begin
    reset = 1'b0; en = 1'b0; up_down = 1'b0; clear = 1'b0; load = 1'b0; load_value = 3'd0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    #12;
    for (int i = 0; i < 3; i++) begin
      chk("rst_cnt", obs_cnt(i), 0);
      chk("rst_wrap", obs_wrap(i), 0);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Up from reset: wrap, saturate and full-range variants side by side.
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 0);
      chk("up_a", int'(cnt_a), seq_a[k]);
      chk("upw_a", int'(wrap_a), wrp_a[k]);
      chk("up_b", int'(cnt_b), seq_b[k]);
      chk("upw_b", int'(wrap_b), wrp_b[k]);
      chk("up_c", int'(cnt_c), seq_c[k]);
      chk("upw_c", int'(wrap_c), wrp_c[k]);
    end

    // Down from 0.
    step(1'b0, 1'b0, 1'b1, 1'b0, 0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 0);
      chk("dn_a", int'(cnt_a), dseq_a[k]);
      chk("dnw_a", int'(wrap_a), dwrp_a[k]);
      chk("dn_b", int'(cnt_b), 0);
      chk("dnw_b", int'(wrap_b), 1);
    end

    // Saturate from 4 up, then from 1 down.
    step(1'b0, 1'b1, 1'b0, 1'b1, 4);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 0);
      chk("sat_up_b", int'(cnt_b), 5);
      chk("sat_upw_b", int'(wrap_b), (k == 0) ? 0 : 1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 0);
      chk("sat_dn_b", int'(cnt_b), 0);
      chk("sat_dnw_b", int'(wrap_b), (k == 0) ? 0 : 1);
    end

    // Priority and load clamp, then hold.
    step(1'b0, 1'b1, 1'b0, 1'b1, 3);
    step(1'b1, 1'b1, 1'b1, 1'b1, 2);
    chk("prio_a", int'(cnt_a), 0);
    chk("priow_a", int'(wrap_a), 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 7);
    chk("clamp_a", int'(cnt_a), 5);
    chk("clamp_c", int'(cnt_c), 7);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 0);
      chk("hold_a", int'(cnt_a), 5);
      chk("hold_tc_a", int'(tc_a), 0);
    end

    // Asynchronous reset mid-count, with a load still pending.
    step(1'b0, 1'b1, 1'b0, 1'b1, 4);
    en = 1'b0; up_down = 1'b1; clear = 1'b0; load = 1'b1; load_value = 3'd2;
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("arst_cnt", obs_cnt(i), 0);
      chk("arst_wrap", obs_wrap(i), 0);
      m_cnt[i] = 0;
    end
    @(posedge clk);
    #1;
    chk("arst_hold", int'(cnt_a), 0);
    load = 1'b0;
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 0);
    chk("arst_up_a", int'(cnt_a), 1);

    // Random traffic against the model.
    for (int k = 0; k < 300; k++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_counter_nbit_updown

// File: doc/counter_nbit_updown.md
Name: counter_nbit_updown

Overview:
- Parametrised up/down counter, generalising the 3-bit free-running counter.
- Adds configurable width and modulus, plus direction, enable, synchronous clear and parallel load.
- Adds wrap or saturate mode, a terminal-count flag and a registered wrap pulse.
- Used as the common counting primitive for timers, dividers and sequencers in the training designs.

Parameters:
- WIDTH, 3, counter width in bits (1..32).
- MOD, 2**WIDTH, modulus; count range 0..MOD-1; legal 2..2**WIDTH.
- SATURATE, 0, 0 = wrap at boundaries; 1 = hold at boundaries.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- en  in  1  count enable.
- up_down  in  1  1 = count up, 0 = count down.
- clear  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load.
- load_value  in  WIDTH  value for load.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal count, combinational.
- wrap  out  1  boundary-event pulse, registered, one cycle.

Behaviour:
- Reset: reset low forces count = 0 and wrap = 0 immediately, independent of clk. Release is taken on the next rising edge; the first update follows that edge.
- Priority each rising edge, highest first: clear, load, en, hold.
- clear = 1: count <= 0, wrap <= 0.
- load = 1 (clear = 0): count <= load_value if load_value < MOD, else count <= MOD-1; wrap <= 0.
- en = 1, up_down = 1:
  - count < MOD-1: count <= count+1.
  - count == MOD-1, SATURATE = 0: count <= 0.
  - count == MOD-1, SATURATE = 1: count holds.
- en = 1, up_down = 0:
  - count > 0: count <= count-1.
  - count == 0, SATURATE = 0: count <= MOD-1.
  - count == 0, SATURATE = 1: count holds.
- en = 0 and no clear/load: count holds; wrap <= 0.
- tc = en & ((up_down & count == MOD-1) | (~up_down & count == 0)). Purely combinational, no latency. It is high in the cycle before a boundary event and is masked by en only, not by clear/load.
- wrap: set to 1 on the edge where an enabled count step occurs at a boundary, i.e. tc = 1 and clear = 0 and load = 0. Otherwise 0. Asserts in both modes, so in SATURATE = 1 it flags an attempted overflow/underflow. A continuous hold at a boundary with en = 1 and SATURATE = 1 gives wrap = 1 every cycle.
- Latency: count reflects inputs one edge later; wrap is aligned with the updated count.
- Direction change mid-count takes effect on the next enabled edge; no glitch, no skipped value.
- Counter arithmetic is done in WIDTH+1 bits internally; no overflow for MOD = 2**WIDTH.
- Reset asserted mid-operation aborts everything; load/clear pending that cycle are discarded.
- Illegal parameters (MOD < 2, MOD > 2**WIDTH) are rejected at elaboration via generate-time error.

Decomposition:
- Shared package counter_pkg holds the mode constants CNT_WRAP = 0 and CNT_SAT = 1, used for SATURATE.
- No sub-module: next-state logic and the register fit in one module of roughly 120-150 lines.
- The boundary comparator is shared between tc and wrap.

Test Plan (all with WIDTH = 3, MOD = 6 unless noted):
- Reset low mid-count at count = 4, asynchronous to clk -> count = 0 and wrap = 0 before the next edge; after release plus 1 enabled up edge, count = 1.
- SATURATE = 0, en = 1, up from 0 for 7 edges -> 1, 2, 3, 4, 5, 0, 1; tc = 1 only while count = 5; wrap = 1 only in the cycle count = 0.
- SATURATE = 0, down from 0 -> 5, 4, ...; tc = 1 at count = 0; wrap = 1 with count = 5.
- SATURATE = 1, up from 4 for 4 edges -> 5, 5, 5, 5; wrap = 1 on the 2nd, 3rd and 4th edges. Repeat down to 0, same pattern.
- Priority: count = 3, clear = 1, load = 1, load_value = 2, en = 1 -> count = 0, wrap = 0. Then load = 1, load_value = 7 -> count = 5 (clamped). Then en = 0 for 3 edges -> count holds at 5, tc = 0.
- Default parameters (WIDTH = 3, MOD = 8), en = 1, up for 10 edges from reset -> 1..7, 0, 1, 2; wrap = 1 once, aligned with count = 0.
